// File: rtl/matmul_core_param_if.sv
// matmul_core_param_if: control and data-memory bus of one matmul core.
//   start                   - level request, sampled by the core in IDLE
//   dim_i, dim_j, dim_k     - A is I x J, B is J x K, D is I x K (row-major)
//   a_base, b_base, d_base  - matrix base addresses in data memory
//   write_en0, addr_data_0,
//   datain0                 - single-port data memory write/address/data
//   dataout0                - memory read data, valid one cycle after address
//   busy, end_process       - core status
// The slave modport is the core; master is the system side (control + memory).
interface matmul_core_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 8
);
    logic              start;
    logic [DIM_W-1:0]  dim_i;
    logic [DIM_W-1:0]  dim_j;
    logic [DIM_W-1:0]  dim_k;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] d_base;
    logic              write_en0;
    logic [ADDR_W-1:0] addr_data_0;
    logic [DATA_W-1:0] datain0;
    logic [DATA_W-1:0] dataout0;
    logic              busy;
    logic              end_process;

    modport master (
        output start, dim_i, dim_j, dim_k, a_base, b_base, d_base, dataout0,
        input  write_en0, addr_data_0, datain0, busy, end_process
    );

    modport slave (
        input  start, dim_i, dim_j, dim_k, a_base, b_base, d_base, dataout0,
        output write_en0, addr_data_0, datain0, busy, end_process
    );
endinterface

// File: rtl/matmul_core_param.sv
// matmul_core_param: hard-wired D = A x B core over a shared single-port
// data memory. Computes only the output rows i with i mod NUM_CORES ==
// CORE_ID, so several instances can split one multiplication.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; returns to IDLE, clears all state
//   bus    - matmul_core_param_if.slave (start/dims/bases in, memory bus,
//            busy and end_process out)
// One memory access per cycle: RD_A, RD_B, MAC, ..., WRITE per D element.
module matmul_core_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DIM_W     = 8,
    parameter int ACC_W     = 40,
    parameter int NUM_CORES = 1,
    parameter int CORE_ID   = 0,
    parameter int SATURATE  = 0
) (
    input logic                  clock,
    input logic                  reset,
    matmul_core_param_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_B  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [31:0] NC  = NUM_CORES;
    localparam logic [31:0] CID = CORE_ID;

    logic [2:0]        state;
    logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
    logic [DIM_W-1:0]  dim_i_r, dim_j_r, dim_k_r;
    logic [ADDR_W-1:0] a_base_r, b_base_r, d_base_r;
    logic [DATA_W-1:0] a_r;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_d;
    logic              degenerate, last_j, last_k, last_row;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;

    // Row-major element address, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [DIM_W-1:0]  row,
        input logic [DIM_W-1:0]  cols,
        input logic [DIM_W-1:0]  col
    );
        return base + ADDR_W'(32'(row) * 32'(cols)) + ADDR_W'(col);
    endfunction

    assign addr_a = elem_addr(a_base_r, i_cnt, dim_j_r, j_cnt);
    assign addr_b = elem_addr(b_base_r, j_cnt, dim_k_r, k_cnt);
    assign addr_d = elem_addr(d_base_r, i_cnt, dim_k_r, k_cnt);

    // Evaluated on the live inputs, since they are only latched on start.
    assign degenerate = (bus.dim_i == '0) || (bus.dim_j == '0) ||
                        (bus.dim_k == '0) || (32'(bus.dim_i) <= CID);

    assign last_j   = (32'(j_cnt) + 32'd1) >= 32'(dim_j_r);
    assign last_k   = (32'(k_cnt) + 32'd1) >= 32'(dim_k_r);
    assign last_row = (32'(i_cnt) + NC) >= 32'(dim_i_r);

    // In MAC, dataout0 carries the B element addressed during RD_B.
    assign acc_next = acc + ACC_W'(a_r) * ACC_W'(bus.dataout0);

    always_comb begin
        result = acc[DATA_W-1:0];
        if (SATURATE != 0 && (acc >> DATA_W) != '0)
            result = '1;
    end

    always_comb begin
        we_o   = 1'b0;
        addr_o = '0;
        data_o = '0;
        case (state)
            S_RD_A:  addr_o = addr_a;
            S_RD_B:  addr_o = addr_b;
            S_WRITE: begin
                we_o   = 1'b1;
                addr_o = addr_d;
                data_o = result;
            end
            default: ;
        endcase
    end

    assign bus.write_en0   = we_o;
    assign bus.addr_data_0 = addr_o;
    assign bus.datain0     = data_o;
    assign bus.busy        = (state == S_RD_A) || (state == S_RD_B) ||
                             (state == S_MAC)  || (state == S_WRITE);
    assign bus.end_process = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            dim_i_r  <= '0;
            dim_j_r  <= '0;
            dim_k_r  <= '0;
            a_base_r <= '0;
            b_base_r <= '0;
            d_base_r <= '0;
            a_r      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        dim_i_r  <= bus.dim_i;
                        dim_j_r  <= bus.dim_j;
                        dim_k_r  <= bus.dim_k;
                        a_base_r <= bus.a_base;
                        b_base_r <= bus.b_base;
                        d_base_r <= bus.d_base;
                        i_cnt    <= DIM_W'(CID);
                        j_cnt    <= '0;
                        k_cnt    <= '0;
                        acc      <= '0;
                        state    <= degenerate ? S_DONE : S_RD_A;
                    end
                end
                S_RD_A: state <= S_RD_B;
                S_RD_B: begin
                    a_r   <= bus.dataout0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (!last_j) begin
                        j_cnt <= j_cnt + DIM_W'(1);
                        state <= S_RD_A;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    acc   <= '0;
                    j_cnt <= '0;
                    if (!last_k) begin
                        k_cnt <= k_cnt + DIM_W'(1);
                        state <= S_RD_A;
                    end else if (!last_row) begin
                        i_cnt <= DIM_W'(32'(i_cnt) + NC);
                        k_cnt <= '0;
                        state <= S_RD_A;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!bus.start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/matmul_core_param.md
# matmul_core_param

Parametrised hard-wired matrix-multiply core, the successor to the microcoded per-core datapath. It computes D = A × B over a shared single-port data memory and owns only the output rows assigned to it (row i where i mod NUM_CORES == CORE_ID). Several instances with different CORE_IDs share the work without any instruction memory. Matrix dimensions and base addresses are runtime inputs, sampled at start.

## Interface
- DATA_W, 16: element width of A, B and D in data memory (unsigned)
- ADDR_W, 8: data memory address width
- DIM_W, 8: width of dimension inputs
- ACC_W, 40: accumulator width; must be ≥ 2*DATA_W
- NUM_CORES, 1: number of cores sharing the multiplication (≥1)
- CORE_ID, 0: this core's index, 0..NUM_CORES-1
- SATURATE, 0: 0 = write low DATA_W bits of the accumulator; 1 = clamp to 2^DATA_W-1
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; sampled in IDLE
- dim_i, dim_j, dim_k  in  DIM_W each  A is I×J, B is J×K, D is I×K; row-major
- a_base, b_base, d_base  in  ADDR_W each  matrix base addresses
- write_en0  out  1  data memory write strobe
- addr_data_0  out  ADDR_W  data memory address
- datain0  out  DATA_W  write data
- dataout0  in  DATA_W  read data; valid one cycle after the address is presented
- busy  out  1  high in every state except IDLE and DONE
- end_process  out  1  high in DONE

## Operation
- Addresses are computed modulo 2^ADDR_W:
  - A[i][j] = a_base + i*J + j
  - B[j][k] = b_base + j*K + k
  - D[i][k] = d_base + i*K + k
- All dimensions, bases, and the start row are latched on the IDLE→run transition. Later input changes are ignored until the core returns to IDLE.
- States:
  - IDLE
    - If start=1 and I=0, J=0, K=0, or CORE_ID ≥ I: go to DONE.
    - Otherwise, if start=1: i=CORE_ID, j=0, k=0, acc=0, go to RD_A.
  - RD_A: addr = A[i][j]; go to RD_B.
  - RD_B: addr = B[j][k]; capture a = dataout0; go to MAC.
  - MAC: acc += a*dataout0 (mod 2^ACC_W).
    - If j < J-1: j++, go to RD_A.
    - Otherwise go to WRITE.
  - WRITE: write_en0=1, addr = D[i][k], datain0 = result; acc=0, j=0.
    - If k < K-1: k++, go to RD_A.
    - Otherwise, if i+NUM_CORES < I: i += NUM_CORES, k=0, go to RD_A.
    - Otherwise go to DONE.
  - DONE: end_process=1; stay while start=1; go to IDLE when start=0.
- result:
  - SATURATE=0: acc[DATA_W-1:0].
  - SATURATE=1: 2^DATA_W-1 if acc ≥ 2^DATA_W, else acc.
- write_en0 is high only in WRITE. addr_data_0 and datain0 are don't-care outside RD_A, RD_B and WRITE, but must be driven, never X.
- Arithmetic is unsigned. No read-after-write hazards: D must not overlap A or B; overlap behaviour is undefined.

## Timing
- Reset (synchronous, dominates start):
  - State goes to IDLE; write_en0, busy, end_process all 0.
  - addr_data_0, datain0, acc and all counters cleared to 0.
- Reset mid-operation: no further write occurs from the next edge on. Rows already written stay in memory.
- Latency:
  - start is seen in IDLE at edge 0; RD_A runs in cycle 1.
  - Each D element takes 3*J+1 cycles.
  - Rows owned Nr = ceil((I-CORE_ID)/NUM_CORES).
  - end_process rises at cycle 1 + Nr*K*(3J+1).
  - Degenerate case (no rows owned, or any dimension 0): end_process rises at cycle 1 with no writes.
- end_process stays high until the first edge with start=0, then falls in the next cycle (IDLE). start held high therefore never restarts the core.
- Products overlap nothing: exactly one memory access per cycle, so the core can share a memory port with an arbiter-free, time-multiplexed peer.

## Test plan
- A=[[1,2],[3,4]] at 0x00, B=[[5,6],[7,8]] at 0x10, D at 0x20, NUM_CORES=1 -> writes 19, 22, 43, 50 at 0x20..0x23; end_process rises at cycle 29 and drops one cycle after start falls.
- Same data, two instances with NUM_CORES=2 (CORE_ID 0 and 1), separate memories preloaded identically -> core0 writes only 0x20/0x21 (19, 22), core1 writes only 0x22/0x23 (43, 50); both end_process at cycle 15.
- DATA_W=8, I=J=K=1, A=200, B=2 -> SATURATE=0 writes 0x90; SATURATE=1 writes 0xFF.
- dim_j=0, or CORE_ID=3 with I=2 -> no write_en0 pulse; end_process at cycle 1.
- Assert reset during MAC of the second element of the 2×2 case -> next cycle IDLE, all outputs 0, only 0x20 written. Restart then yields the full correct D.
- a_base=0xFE, I=1, J=3 -> A addresses read are 0xFE, 0xFF, 0x00 (wrap); values still accumulate correctly.
